fir_stream_ctrl: RTL and testbench
==================================

# fir_stream_ctrl

Sequencer for the FIR datapath. Loads a coefficient set into the filter, then paces samples from the sample source (the counter stream) into the filter's `rIn`/`dataIn` strobe port at a programmable rate. On stop it flushes the delay line with zero samples so the last real outputs are produced. Sits between the sample source and `firFilter` in the FPGA top, driven by board-level start/stop/enable.

## Interface
- `TAPS`, default 4: number of filter taps and coefficients.
- `DATA_W`, default 16: sample and coefficient width.
- `DIV_W`, default 8: width of the rate divider.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; 0 freezes all state, counters and strobes.
- `start`  in  1  one-cycle pulse; begins a run from IDLE.
- `stop`  in  1  one-cycle pulse; ends a run.
- `div`  in  DIV_W  sample period minus one, captured on `start`.
- `coef_in`  in  DATA_W  coefficient data.
- `coef_valid` in 1 / `coef_ready` out 1: coefficient handshake.
- `src_data`  in  DATA_W  source sample.
- `src_valid` in 1 / `src_ready` out 1: source handshake.
- `fir_strobe`  out  1  sample strobe to the filter (`rIn`).
- `fir_data`  out  DATA_W  sample to the filter (`dataIn`).
- `fir_coef_we`  out  1  coefficient write enable.
- `fir_coef_addr`  out  clog2(TAPS)  coefficient index.
- `fir_coef_data`  out  DATA_W  coefficient value.
- `busy`  out  1  high in LOAD, RUN, FLUSH.
- `done`  out  1  one-cycle pulse on the transition from FLUSH to IDLE.

## Operation
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE: `start`=1 captures `div` into `div_q`, clears the coefficient index, and goes to LOAD. `stop` is ignored.
- LOAD: `coef_ready`=1. Each `coef_valid&&coef_ready` cycle sets `fir_coef_we`=1, `fir_coef_addr`=index and `fir_coef_data`=`coef_in`, all registered, then increments the index. After write TAPS-1 the block enters RUN and clears the divider. `stop` in LOAD aborts to IDLE with no flush and no `done`.
- Divider (RUN and FLUSH): `cnt` counts 0..`div_q`; `tick`=(`cnt`==`div_q`), then `cnt` wraps to 0. `div_q`=0 gives a tick every cycle.
- RUN: `src_ready` = `tick`&&`en`. On `tick`&&`src_valid`, the next cycle has `fir_strobe`=1 and `fir_data`=`src_data`. On `tick` with `src_valid`=0 there is no strobe and the slot is lost; the divider keeps running.
- `stop` in RUN goes to FLUSH with the flush count set to 0. `stop` and a sample transfer in the same cycle: the transfer completes, then FLUSH.
- FLUSH: `src_ready`=0. On each `tick`, `fir_strobe`=1 and `fir_data`=0. After TAPS-1 zero strobes the block goes to IDLE and pulses `done`.
- `en`=0 holds state, `cnt`, index and flush count. It forces `fir_strobe`, `fir_coef_we`, `src_ready` and `coef_ready` to 0. `start`/`stop` pulses during `en`=0 are dropped.
- `start` while busy is ignored.
- `div` changes mid-run have no effect until the next `start`.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `cnt`, index and flush count 0; all outputs 0, including `fir_data`, `fir_coef_*`, `busy` and `done`.
- Reset release is synchronous to the first rising edge with `rst`=1.
- `start` to `busy`=1: 1 cycle.
- Coefficient handshake to `fir_coef_we`: 1 cycle. Last handshake to state RUN: 1 cycle.
- First RUN tick arrives `div_q`+1 cycles after entering RUN.
- Source handshake to `fir_strobe`: 1 cycle. Strobes are exactly one cycle wide and at least `div_q`+1 cycles apart.
- `stop` to first flush strobe: `div_q`+1 cycles at most.
- Last flush strobe to `done`: 1 cycle. `busy` drops in the same cycle as `done`.
- Reset asserted mid-run: outputs go to 0 immediately, with no flush and no `done`.

## Structure
- Shared package `fir_pkg` holds:
  - the state enum `fir_ctrl_state_t` (IDLE, LOAD, RUN, FLUSH);
  - `FIR_TAPS_DEF` and `FIR_DATA_W_DEF`, also used by `firFilter`.
- One sub-module, `rate_divider`: `cnt`/`tick` generation with load, clear and enable inputs.
- The FSM, index counter and flush counter stay in `fir_stream_ctrl`.

## Test plan
- Load and run, `div`=0, TAPS=4: coefficients 1,2,3,4 give writes at addresses 0..3. Source ramp 0,1,2,… then gives strobes on consecutive cycles with `fir_data` 0,1,2,…
- Rate pacing, `div`=3: strobes exactly 4 cycles apart. With `src_valid` dropped for one tick, that slot has no strobe and the next strobe is still on the 4-cycle grid.
- `stop` in RUN, `div`=1: exactly 3 strobes with `fir_data`=0, 2 cycles apart, then `done` for one cycle and `busy`=0.
- `stop` during LOAD after 2 coefficients: return to IDLE, only 2 writes, no flush strobes, `done` stays 0.
- `en`=0 for 5 cycles mid-RUN: no strobes and `cnt` frozen. Pacing resumes with the same phase; `start` pulsed during `en`=0 has no effect.
- `rst` asserted between strobes in FLUSH: all outputs 0 asynchronously. After release, a new `start` runs LOAD normally from address 0.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR types and default sizes
package fir_pkg;

  localparam int FIR_TAPS_DEF   = 4;
  localparam int FIR_DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } fir_ctrl_state_t;

endpackage

// File: rtl/fir_stream_ctrl_rate_divider.sv
// rtl/fir_stream_ctrl_rate_divider.sv - programmable sample-period counter
module rate_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // A period of div_q+1 cycles; div_q=0 ticks every cycle.
  assign tick_o = (cnt_q == div_q);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  // Period is captured once per run and ignored afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else if (load_i) begin
      div_q <= div_i;
    end
  end

  // Phase counter: held at zero while cleared, frozen while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - FIR sequencer: coefficient load, paced sample run, zero flush
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter  int TAPS   = FIR_TAPS_DEF,
  parameter  int DATA_W = FIR_DATA_W_DEF,
  parameter  int DIV_W  = 8,
  localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DATA_W-1:0] coef_in_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic              fir_strobe_o,
  output logic [DATA_W-1:0] fir_data_o,
  output logic              fir_coef_we_o,
  output logic [AW-1:0]     fir_coef_addr_o,
  output logic [DATA_W-1:0] fir_coef_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_ctrl_state_t   state_q;
  logic [AW-1:0]     idx_q;
  logic [AW-1:0]     flush_q;
  logic              strobe_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic [AW-1:0]     caddr_q;
  logic [DATA_W-1:0] cdata_q;
  logic              busy_q;
  logic              done_q;
  logic              running;
  logic              div_tick;

  assign running = (state_q == RUN) || (state_q == FLUSH);

  rate_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i && running),
    .clr_i  (!running),
    .load_i (en_i && (state_q == IDLE) && start_i),
    .div_i  (div_i),
    .tick_o (div_tick)
  );

  // Handshake readies are combinational so a transfer completes in the offered cycle.
  assign coef_ready_o = en_i && (state_q == LOAD);
  assign src_ready_o  = en_i && (state_q == RUN) && div_tick;

  // Strobes are masked while disabled so a held-over pulse never reaches the filter.
  assign fir_strobe_o    = strobe_q && en_i;
  assign fir_data_o      = data_q;
  assign fir_coef_we_o   = we_q && en_i;
  assign fir_coef_addr_o = caddr_q;
  assign fir_coef_data_o = cdata_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  // Sequencer FSM with index/flush counters and registered filter-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      flush_q  <= '0;
      strobe_q <= 1'b0;
      data_q   <= '0;
      we_q     <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      if (en_i) begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q <= LOAD;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            if (stop_i) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (coef_valid_i) begin
              we_q    <= 1'b1;
              caddr_q <= idx_q;
              cdata_q <= coef_in_i;
              idx_q   <= idx_q + 1'b1;
              if (idx_q == LAST) begin
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            if (div_tick && src_valid_i) begin
              strobe_q <= 1'b1;
              data_q   <= src_data_i;
            end
            if (stop_i) begin
              state_q <= FLUSH;
              flush_q <= '0;
            end
          end
          FLUSH: begin
            // The exit check sits one cycle after the last zero strobe so done follows it.
            if (flush_q == LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (div_tick) begin
              strobe_q <= 1'b1;
              data_q   <= '0;
              flush_q  <= flush_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - directed bench for fir_stream_ctrl
module tb_fir_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        stop;
  logic [7:0]  div;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        fir_strobe;
  logic [15:0] fir_data;
  logic        fir_coef_we;
  logic [1:0]  fir_coef_addr;
  logic [15:0] fir_coef_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base;

  int          s_cyc[$];
  logic [15:0] s_dat[$];
  logic [1:0]  w_addr[$];
  logic [15:0] w_dat[$];
  int          d_cyc[$];
  logic        d_busy[$];

  fir_stream_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .en_i            (en),
    .start_i         (start),
    .stop_i          (stop),
    .div_i           (div),
    .coef_in_i       (coef_in),
    .coef_valid_i    (coef_valid),
    .coef_ready_o    (coef_ready),
    .src_data_i      (src_data),
    .src_valid_i     (src_valid),
    .src_ready_o     (src_ready),
    .fir_strobe_o    (fir_strobe),
    .fir_data_o      (fir_data),
    .fir_coef_we_o   (fir_coef_we),
    .fir_coef_addr_o (fir_coef_addr),
    .fir_coef_data_o (fir_coef_data),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (fir_strobe) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(fir_data);
    end
    if (fir_coef_we) begin
      w_addr.push_back(fir_coef_addr);
      w_dat.push_back(fir_coef_data);
    end
    if (done) begin
      d_cyc.push_back(cyc);
      d_busy.push_back(busy);
    end
  end

  typedef struct {
    logic        start;
    logic        cv;
    logic [15:0] coef;
    logic        sv;
    logic [15:0] sd;
    logic        e_strobe;
    logic [15:0] e_data;
    logic        e_we;
    logic [1:0]  e_addr;
    logic [15:0] e_cdata;
    logic        e_busy;
    logic        e_cready;
    logic        e_sready;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clr_q();
    s_cyc.delete(); s_dat.delete();
    w_addr.delete(); w_dat.delete();
    d_cyc.delete(); d_busy.delete();
  endtask

  task automatic idle_inputs();
    en = 1'b1; start = 1'b0; stop = 1'b0; div = 8'd0;
    coef_in = 16'd0; coef_valid = 1'b0; src_data = 16'd0; src_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_q();
  endtask

  // Coefficients b, b+1, b+2, b+3; returns at the first RUN cycle with the divider at zero.
  task automatic load_coefs(input logic [7:0] d, input logic [15:0] b);
    start = 1'b1; div = d;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      coef_valid = 1'b1;
      coef_in = b + 16'(k);
      @(negedge clk);
    end
    coef_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'd1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 2'd0, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'd3, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 2'd1, 16'd2, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'd4, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 2'd2, 16'd3, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd5, 1'b0, 16'd0, 1'b1, 2'd3, 16'd4, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd6, 1'b1, 16'd5, 1'b0, 2'd3, 16'd4, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd7, 1'b1, 16'd6, 1'b0, 2'd3, 16'd4, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 16'd7, 1'b0, 2'd3, 16'd4, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd7, 1'b0, 2'd3, 16'd4, 1'b1, 1'b0, 1'b1};

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_strobe", fir_strobe, 0);
    chk("rst_data", fir_data, 0);
    chk("rst_we", fir_coef_we, 0);
    chk("rst_addr", fir_coef_addr, 0);
    chk("rst_cdata", fir_coef_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cready", coef_ready, 0);
    chk("rst_sready", src_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_q();

    // Load 1..4 then run at div=0, cycle by cycle from the table
    div = 8'd0;
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; coef_valid = tbl[i].cv; coef_in = tbl[i].coef;
      src_valid = tbl[i].sv; src_data = tbl[i].sd;
      #1;
      chk($sformatf("v%0d_strobe", i), fir_strobe, tbl[i].e_strobe);
      chk($sformatf("v%0d_data", i), fir_data, tbl[i].e_data);
      chk($sformatf("v%0d_we", i), fir_coef_we, tbl[i].e_we);
      chk($sformatf("v%0d_addr", i), fir_coef_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_cdata", i), fir_coef_data, tbl[i].e_cdata);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_cready", i), coef_ready, tbl[i].e_cready);
      chk($sformatf("v%0d_sready", i), src_ready, tbl[i].e_sready);
      chk($sformatf("v%0d_done", i), done, 0);
      @(negedge clk);
    end

    // Rate pacing at div=3 with one missed slot
    do_reset();
    load_coefs(8'd3, 16'h10);
    base = cyc;
    for (int j = 0; j < 16; j++) begin
      src_valid = (j != 7);
      src_data = 16'(100 + j);
      @(negedge clk);
    end
    src_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pace_cnt", s_cyc.size(), 3);
    if (s_cyc.size() == 3) begin
      chk("pace_t0", s_cyc[0], base + 4);
      chk("pace_t1", s_cyc[1], base + 12);
      chk("pace_t2", s_cyc[2], base + 16);
      chk("pace_d0", s_dat[0], 103);
      chk("pace_d1", s_dat[1], 111);
      chk("pace_d2", s_dat[2], 115);
    end
    chk("pace_wcnt", w_addr.size(), 4);
    if (w_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("pace_waddr%0d", k), w_addr[k], k);
        chk($sformatf("pace_wdat%0d", k), w_dat[k], 16'h10 + k);
      end
    end

    // Stop in RUN at div=1: one real sample, three zero strobes, then done
    do_reset();
    load_coefs(8'd1, 16'h20);
    base = cyc;
    for (int j = 0; j < 12; j++) begin
      src_valid = (j == 1);
      src_data = (j == 1) ? 16'hABCD : 16'h0000;
      stop = (j == 2);
      @(negedge clk);
    end
    stop = 1'b0; src_valid = 1'b0;
    chk("flush_cnt", s_cyc.size(), 4);
    if (s_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("flush_t%0d", k), s_cyc[k], base + 2 + 2 * k);
        chk($sformatf("flush_d%0d", k), s_dat[k], (k == 0) ? 16'hABCD : 16'h0000);
      end
    end
    chk("flush_done_cnt", d_cyc.size(), 1);
    if (d_cyc.size() == 1) begin
      chk("flush_done_t", d_cyc[0], base + 9);
      chk("flush_done_busy", d_busy[0], 0);
    end
    #1;
    chk("flush_busy_end", busy, 0);

    // Stop during LOAD after two coefficients
    do_reset();
    start = 1'b1; div = 8'd0;
    @(negedge clk);
    start = 1'b0; coef_valid = 1'b1; coef_in = 16'd11;
    @(negedge clk);
    coef_in = 16'd22;
    @(negedge clk);
    coef_valid = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; src_valid = 1'b1; coef_valid = 1'b1; coef_in = 16'd33;
    repeat (8) @(negedge clk);
    #1;
    chk("abort_cready", coef_ready, 0);
    chk("abort_busy", busy, 0);
    coef_valid = 1'b0; src_valid = 1'b0;
    chk("abort_wcnt", w_addr.size(), 2);
    if (w_addr.size() == 2) begin
      chk("abort_a0", w_addr[0], 0);
      chk("abort_a1", w_addr[1], 1);
      chk("abort_d0", w_dat[0], 11);
      chk("abort_d1", w_dat[1], 22);
    end
    chk("abort_strobes", s_cyc.size(), 0);
    chk("abort_done", d_cyc.size(), 0);

    // en=0 for five cycles mid-RUN with start/stop pulses dropped
    do_reset();
    load_coefs(8'd3, 16'h30);
    base = cyc;
    for (int j = 0; j < 20; j++) begin
      en = !(j >= 5 && j <= 9);
      start = (j == 7);
      stop = (j == 8);
      src_valid = 1'b1;
      src_data = 16'(200 + j);
      @(negedge clk);
    end
    en = 1'b1; start = 1'b0; stop = 1'b0; src_valid = 1'b0;
    #1;
    chk("hold_busy", busy, 1);
    chk("hold_cnt", s_cyc.size(), 3);
    if (s_cyc.size() == 3) begin
      chk("hold_t0", s_cyc[0], base + 4);
      chk("hold_t1", s_cyc[1], base + 13);
      chk("hold_t2", s_cyc[2], base + 17);
      chk("hold_d0", s_dat[0], 203);
      chk("hold_d1", s_dat[1], 212);
      chk("hold_d2", s_dat[2], 216);
    end
    chk("hold_done", d_cyc.size(), 0);

    // Reset in FLUSH between strobes, then a clean reload
    do_reset();
    load_coefs(8'd3, 16'h40);
    for (int j = 0; j < 6; j++) begin
      src_valid = (j == 3);
      src_data = 16'h1234;
      stop = (j == 4);
      @(negedge clk);
    end
    stop = 1'b0; src_valid = 1'b0;
    #1;
    chk("pre_rst_data", fir_data, 16'h1234);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_strobes", s_cyc.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_strobe", fir_strobe, 0);
    chk("arst_data", fir_data, 0);
    chk("arst_we", fir_coef_we, 0);
    chk("arst_addr", fir_coef_addr, 0);
    chk("arst_cdata", fir_coef_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sready", src_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_q();
    load_coefs(8'd0, 16'h50);
    repeat (3) @(negedge clk);
    chk("reload_wcnt", w_addr.size(), 4);
    if (w_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("reload_waddr%0d", k), w_addr[k], k);
        chk($sformatf("reload_wdat%0d", k), w_dat[k], 16'h50 + k);
      end
    end
    chk("reload_strobes", s_cyc.size(), 0);
    chk("reload_done", d_cyc.size(), 0);
    #1;
    chk("reload_busy", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
